// File: rtl/mem_port_arbiter_if.sv
// Signal bundle joining the fetch/data requesters and the shared memory port to the arbiter.
interface mem_port_arbiter_if;
    logic [31:0] req0_addr;
    logic        req0_read;
    logic        req0_write;
    logic [3:0]  req0_wmask;
    logic [31:0] req0_wdata;
    logic [31:0] req0_rdata;
    logic        req0_resp;

    logic [31:0] req1_addr;
    logic        req1_read;
    logic        req1_write;
    logic [3:0]  req1_wmask;
    logic [31:0] req1_wdata;
    logic [31:0] req1_rdata;
    logic        req1_resp;

    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    // Arbiter side
    modport slave (
        input  req0_addr, req0_read, req0_write, req0_wmask, req0_wdata,
        output req0_rdata, req0_resp,
        input  req1_addr, req1_read, req1_write, req1_wmask, req1_wdata,
        output req1_rdata, req1_resp,
        output mem_addr, mem_read, mem_write, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    // Requester/memory side
    modport master (
        output req0_addr, req0_read, req0_write, req0_wmask, req0_wdata,
        input  req0_rdata, req0_resp,
        output req1_addr, req1_read, req1_write, req1_wmask, req1_wdata,
        input  req1_rdata, req1_resp,
        input  mem_addr, mem_read, mem_write, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (0) and data (1) requesters,
// with a sticky error flag for protocol faults and a non-responding memory.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic              owner,
    output logic              busy,
    output logic              error
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic                owner_d, error_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                read_q, read_d;
    logic                write_q, write_d;

    logic                pend0, pend1, gnt;
    logic                sel_read, sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [MASK_W-1:0]   sel_wmask;
    logic [DATA_W-1:0]   sel_wdata;
    logic                done;

    // Grant choice: lone pending requester wins, otherwise the round-robin pointer decides
    assign pend0     = bus.req0_read | bus.req0_write;
    assign pend1     = bus.req1_read | bus.req1_write;
    assign gnt       = (pend0 & pend1) ? rr_q : pend1;
    assign sel_read  = gnt ? bus.req1_read  : bus.req0_read;
    assign sel_write = gnt ? bus.req1_write : bus.req0_write;
    assign sel_addr  = gnt ? bus.req1_addr  : bus.req0_addr;
    assign sel_wmask = gnt ? bus.req1_wmask : bus.req0_wmask;
    assign sel_wdata = gnt ? bus.req1_wdata : bus.req0_wdata;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner;
        error_d = error;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        read_d  = read_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_resp) error_d = 1'b1;
                if (pend0 | pend1) begin
                    state_d = BUSY;
                    owner_d = gnt;
                    rr_d    = ~gnt;
                    addr_d  = sel_addr;
                    wmask_d = sel_wmask;
                    wdata_d = sel_wdata;
                    write_d = sel_write;
                    // read+write together is forwarded as a write and flagged
                    read_d  = sel_read & ~sel_write;
                    cnt_d   = '0;
                    if (sel_read & sel_write) error_d = 1'b1;
                end
            end
            BUSY: begin
                if (bus.mem_resp) begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                end else if (cnt_q != TIMEOUT) begin
                    // watchdog saturates at the limit; the transaction is not aborted
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == TIMEOUT) error_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner   <= 1'b0;
            error   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wmask_q <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner   <= owner_d;
            error   <= error_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

    assign busy          = (state_q == BUSY);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_read  = read_q;
    assign bus.mem_write = write_q;

    // Completion is passed straight through to the owner in the same cycle
    assign done           = busy & bus.mem_resp;
    assign bus.req0_resp  = done & ~owner;
    assign bus.req1_resp  = done & owner;
    assign bus.req0_rdata = bus.req0_resp ? bus.mem_rdata : '0;
    assign bus.req1_rdata = bus.req1_resp ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic owner, busy, error;
    int   n_tests = 0;
    int   n_fail  = 0;

    // memory responder knobs
    bit          mem_en;
    bit          mem_rand;
    bit          mem_fix;
    logic [31:0] mem_fix_val;
    int          mem_lat;
    int          wait_cnt;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .owner(owner), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // One clock: memory reacts just after the edge, caller resumes at the falling edge
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_en) begin
            bus.mem_resp = 1'b0;
            if (bus.mem_read || bus.mem_write) begin
                wait_cnt++;
                if (wait_cnt == mem_lat + 1) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = mem_fix ? mem_fix_val : $urandom();
                    wait_cnt      = 0;
                    if (mem_rand) mem_lat = int'($urandom_range(0, 5));
                end
            end else begin
                wait_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [3:0] m, input logic [31:0] d);
        if (i == 0) begin
            bus.req0_read = rd; bus.req0_write = wr; bus.req0_addr = a;
            bus.req0_wmask = m; bus.req0_wdata = d;
        end else begin
            bus.req1_read = rd; bus.req1_write = wr; bus.req1_addr = a;
            bus.req1_wmask = m; bus.req1_wdata = d;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        mem_en = 0; mem_rand = 0; mem_fix = 0; mem_fix_val = '0; mem_lat = 1; wait_cnt = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [71:0] v;
        rst = 1'b1;
        set_req(0, 1, 0, 32'h44, 4'hF, 32'h1);
        set_req(1, 0, 1, 32'h88, 4'hF, 32'h2);
        bus.mem_resp = 1'b0; bus.mem_rdata = '0; mem_en = 0;
        step(); step();
        v = {busy, error, owner, bus.mem_read, bus.mem_write, bus.mem_wmask, bus.mem_addr, bus.mem_wdata};
        n_tests++;
        if (v !== 72'h0) begin
            n_fail++; $display("FAIL reset_values: got %h required 0", v);
        end
        set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        n_tests++;
        if ({busy, bus.mem_read, bus.mem_write, bus.req0_resp, bus.req1_resp} !== 5'b0) begin
            n_fail++; $display("FAIL reset_idle: busy=%b rd=%b wr=%b required 0", busy, bus.mem_read, bus.mem_write);
        end
    endtask

    task automatic test_single_read();
        int n0 = 0, n1 = 0, at = -1;
        logic [31:0] rd = '0;
        logic after = 1'b1;
        do_reset();
        mem_en = 1; mem_lat = 3; mem_fix = 1; mem_fix_val = 32'hDEAD_BEEF;
        set_req(0, 1, 0, 32'h0000_1000, 4'h0, 32'h0);
        step();
        n_tests++;
        if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h1000 || busy !== 1'b1 || owner !== 1'b0) begin
            n_fail++; $display("FAIL single_grant: rd=%b wr=%b addr=%h busy=%b owner=%b required 1 0 1000 1 0",
                               bus.mem_read, bus.mem_write, bus.mem_addr, busy, owner);
        end
        for (int c = 2; c <= 20; c++) begin
            step();
            if (c == at + 1) after = bus.mem_read;
            if (bus.req0_resp === 1'b1) begin
                n0++; rd = bus.req0_rdata; at = c;
                set_req(0, 0, 0, 0, 0, 0);
            end
            if (bus.req1_resp !== 1'b0) n1++;
        end
        n_tests++;
        if (n0 != 1 || at != 4 || rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_resp: pulses=%0d cycle=%0d rdata=%h required 1 4 deadbeef", n0, at, rd);
        end
        n_tests++;
        if (n1 != 0 || after !== 1'b0) begin
            n_fail++; $display("FAIL single_other: req1_resp=%0d mem_read_after=%b required 0 0", n1, after);
        end
    endtask

    task automatic test_simultaneous();
        logic s_own[2], s_rd[2], s_wr[2];
        logic [31:0] s_addr[2], s_data[2];
        logic [3:0]  s_mask[2];
        logic [31:0] got0 = '0, exp0 = '1;
        logic prev = 1'b0, strobe;
        int starts = 0, idle_between = 0;
        bit d0 = 0, d1 = 0;
        do_reset();
        mem_en = 1; mem_lat = 1;
        set_req(0, 1, 0, 32'h100, 4'h0, 32'h0);
        set_req(1, 0, 1, 32'h200, 4'b0011, 32'h1234_5678);
        for (int c = 0; c < 40 && !(d0 && d1); c++) begin
            step();
            strobe = bus.mem_read | bus.mem_write;
            if (strobe && !prev) begin
                if (starts < 2) begin
                    s_own[starts] = owner; s_rd[starts] = bus.mem_read; s_wr[starts] = bus.mem_write;
                    s_addr[starts] = bus.mem_addr; s_data[starts] = bus.mem_wdata; s_mask[starts] = bus.mem_wmask;
                end
                starts++;
            end
            if (!strobe && starts == 1) idle_between++;
            if (bus.req0_resp === 1'b1) begin
                d0 = 1; got0 = bus.req0_rdata; exp0 = bus.mem_rdata; set_req(0, 0, 0, 0, 0, 0);
            end
            if (bus.req1_resp === 1'b1) begin
                d1 = 1; set_req(1, 0, 0, 0, 0, 0);
            end
            prev = strobe;
        end
        n_tests++;
        if (starts != 2 || !d0 || !d1) begin
            n_fail++; $display("FAIL simul_count: starts=%0d done=%b%b required 2 11", starts, d0, d1);
        end else begin
            n_tests++;
            if (s_own[0] !== 1'b0 || s_rd[0] !== 1'b1 || s_wr[0] !== 1'b0 || s_addr[0] !== 32'h100 || got0 !== exp0) begin
                n_fail++; $display("FAIL simul_first: owner=%b rd=%b wr=%b addr=%h rdata=%h required 0 1 0 100 %h",
                                   s_own[0], s_rd[0], s_wr[0], s_addr[0], got0, exp0);
            end
            n_tests++;
            if (s_own[1] !== 1'b1 || s_rd[1] !== 1'b0 || s_wr[1] !== 1'b1 || s_addr[1] !== 32'h200 ||
                s_mask[1] !== 4'b0011 || s_data[1] !== 32'h1234_5678) begin
                n_fail++; $display("FAIL simul_second: owner=%b rd=%b wr=%b addr=%h mask=%b data=%h required 1 0 1 200 0011 12345678",
                                   s_own[1], s_rd[1], s_wr[1], s_addr[1], s_mask[1], s_data[1]);
            end
            n_tests++;
            if (idle_between != 1) begin
                n_fail++; $display("FAIL simul_gap: idle cycles=%0d required 1", idle_between);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] order = '0;
        logic prev = 1'b0, strobe;
        int starts = 0, gap = 0, bad_gaps = 0;
        do_reset();
        mem_en = 1; mem_rand = 1; mem_lat = 2;
        set_req(0, 1, 0, 32'h10, 4'h0, 32'h0);
        set_req(1, 1, 0, 32'h20, 4'h0, 32'h0);
        for (int c = 0; c < 300 && starts < 6; c++) begin
            step();
            strobe = bus.mem_read | bus.mem_write;
            if (strobe && !prev) begin
                order[starts] = owner;
                if (starts > 0 && gap != 1) bad_gaps++;
                starts++;
                gap = 0;
            end
            if (!strobe) gap++;
            prev = strobe;
        end
        n_tests++;
        if (starts != 6 || order !== 6'b101010) begin
            n_fail++; $display("FAIL fair_order: starts=%0d order(lsb first)=%b required 6 101010", starts, order);
        end
        n_tests++;
        if (bad_gaps != 0) begin
            n_fail++; $display("FAIL fair_gap: gaps not equal to 1 = %0d required 0", bad_gaps);
        end
    endtask

    task automatic test_busy_change();
        int bad = 0;
        bit done = 0;
        do_reset();
        mem_en = 1; mem_lat = 4;
        set_req(0, 1, 0, 32'h1000, 4'h0, 32'h0);
        step();
        set_req(0, 1, 0, 32'h2000, 4'hF, 32'hFFFF_0000);
        for (int c = 0; c < 20 && !done; c++) begin
            if (bus.mem_addr !== 32'h1000 || busy !== 1'b1) bad++;
            if (bus.req0_resp === 1'b1) done = 1;
            else step();
        end
        n_tests++;
        if (!done || bad != 0) begin
            n_fail++; $display("FAIL busy_hold: done=%b bad cycles=%0d required 1 0", done, bad);
        end
        step();
        n_tests++;
        if (bus.mem_read !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL turnaround_idle: rd=%b busy=%b required 0 0", bus.mem_read, busy);
        end
        step();
        n_tests++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h2000) begin
            n_fail++; $display("FAIL rerequest: rd=%b addr=%h required 1 2000", bus.mem_read, bus.mem_addr);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_req(0, 1, 0, 32'h40, 4'h0, 32'h0);
        for (int k = 1; k <= 8; k++) step();
        n_tests++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_early: error=%b busy=%b required 0 1", error, busy);
        end
        step();
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL timeout_hit: error=%b busy=%b required 1 1", error, busy);
        end
        for (int k = 0; k < 5; k++) step();
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b1 || bus.mem_read !== 1'b1) begin
            n_fail++; $display("FAIL timeout_stay: error=%b busy=%b rd=%b required 1 1 1", error, busy, bus.mem_read);
        end
        rst = 1'b1;
        set_req(0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        n_tests++;
        if (error !== 1'b0 || busy !== 1'b0 || bus.mem_read !== 1'b0 || bus.req0_resp !== 1'b0) begin
            n_fail++; $display("FAIL timeout_reset: error=%b busy=%b rd=%b required 0 0 0", error, busy, bus.mem_read);
        end
    endtask

    task automatic test_protocol_faults();
        bit done = 0;
        do_reset();
        mem_en = 1; mem_lat = 1;
        set_req(1, 1, 1, 32'h300, 4'hF, 32'hCAFE_F00D);
        step();
        n_tests++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || owner !== 1'b1 || error !== 1'b1) begin
            n_fail++; $display("FAIL rw_both: wr=%b rd=%b owner=%b error=%b required 1 0 1 1",
                               bus.mem_write, bus.mem_read, owner, error);
        end
        for (int c = 0; c < 10 && !done; c++) begin
            step();
            if (bus.req1_resp === 1'b1) begin done = 1; set_req(1, 0, 0, 0, 0, 0); end
        end
        step(); step();
        n_tests++;
        if (!done || error !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rw_sticky: done=%b error=%b busy=%b required 1 1 0", done, error, busy);
        end
        do_reset();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        step();
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b0 || bus.req0_resp !== 1'b0 || bus.req1_resp !== 1'b0 || bus.req0_rdata !== 32'h0) begin
            n_fail++; $display("FAIL spurious_resp: error=%b busy=%b resp=%b%b required 1 0 00",
                               error, busy, bus.req0_resp, bus.req1_resp);
        end
        bus.mem_resp = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_tests++;
        if (error !== 1'b1) begin
            n_fail++; $display("FAIL spurious_sticky: error=%b required 1", error);
        end
        do_reset();
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL error_clear: error=%b required 0", error);
        end
    endtask

    // Transaction-level reference: grant winner from pending set and preference, latched request fields
    task automatic test_random();
        bit act[2];
        logic rd[2], wr[2];
        logic [31:0] ad[2], wd[2];
        logic [3:0]  wm[2];
        bit m_busy = 0, m_own = 0, m_pref = 0, g;
        logic m_rd = 0, m_wr = 0;
        logic [31:0] m_addr = '0, m_wdata = '0;
        logic [3:0]  m_wmask = '0;
        logic exp_r[2];
        logic [31:0] exp_d[2];
        bit ok;
        do_reset();
        mem_en = 1; mem_rand = 1; mem_lat = 2;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; rd[i] = 0; wr[i] = 0; ad[i] = '0; wd[i] = '0; wm[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                exp_r[i] = m_busy && (int'(m_own) == i) && bus.mem_resp;
                exp_d[i] = exp_r[i] ? bus.mem_rdata : 32'h0;
            end
            ok = (busy === m_busy) && (error === 1'b0) &&
                 (bus.req0_resp === exp_r[0]) && (bus.req1_resp === exp_r[1]) &&
                 (bus.req0_rdata === exp_d[0]) && (bus.req1_rdata === exp_d[1]);
            if (m_busy)
                ok = ok && (owner === m_own) && (bus.mem_read === m_rd) && (bus.mem_write === m_wr) &&
                     (bus.mem_addr === m_addr) && (bus.mem_wmask === m_wmask) && (bus.mem_wdata === m_wdata);
            else
                ok = ok && (bus.mem_read === 1'b0) && (bus.mem_write === 1'b0);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL random c%0d: busy=%b/%b owner=%b/%b rd=%b/%b wr=%b/%b addr=%h/%h mask=%h/%h data=%h/%h resp=%b%b/%b%b err=%b/0",
                         c, busy, m_busy, owner, m_own, bus.mem_read, m_rd, bus.mem_write, m_wr, bus.mem_addr, m_addr,
                         bus.mem_wmask, m_wmask, bus.mem_wdata, m_wdata, bus.req0_resp, bus.req1_resp,
                         exp_r[0], exp_r[1], error);
            end
            for (int i = 0; i < 2; i++) begin
                if ((act[i] && exp_r[i] && $urandom_range(0, 1) == 1) || (!act[i] && $urandom_range(0, 2) == 0)) begin
                    act[i] = 1; wr[i] = 1'($urandom_range(0, 1)); rd[i] = ~wr[i];
                    ad[i] = $urandom(); wd[i] = $urandom(); wm[i] = 4'($urandom());
                end else if (act[i] && exp_r[i]) begin
                    act[i] = 0; rd[i] = 0; wr[i] = 0;
                end
                set_req(i, rd[i], wr[i], ad[i], wm[i], wd[i]);
            end
            if (m_busy) begin
                if (bus.mem_resp) m_busy = 0;
            end else if (act[0] || act[1]) begin
                g = (act[0] && act[1]) ? m_pref : act[1];
                m_own = g; m_pref = !g; m_busy = 1;
                m_rd = rd[g]; m_wr = wr[g]; m_addr = ad[g]; m_wmask = wm[g]; m_wdata = wd[g];
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_busy_change();
        test_timeout();
        test_protocol_faults();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
